// File: rtl/cpu_td_n.sv
// N-bit accumulator CPU with the TD4-style instruction set.
// One instruction executes per enabled clock; the instruction ROM is external and combinational.
module cpu_td_n #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W+3:0] data,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] led,
  output logic              c_flag
);

  localparam int TGT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_led;
  logic              r_c;

  logic [3:0]        w_opcode;
  logic [DATA_W-1:0] w_imm;
  logic [TGT_W-1:0]  w_imm_ext;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [DATA_W:0]   w_sum_a;
  logic [DATA_W:0]   w_sum_b;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] w_a_nxt;
  logic [DATA_W-1:0] w_b_nxt;
  logic [DATA_W-1:0] w_led_nxt;
  logic              w_c_nxt;

  assign w_opcode  = data[DATA_W+3:DATA_W];
  assign w_imm     = data[DATA_W-1:0];
  // Widen first so the jump target zero-extends or truncates as the widths dictate.
  assign w_imm_ext = TGT_W'(w_imm);
  assign w_target  = w_imm_ext[ADDR_W-1:0];
  assign w_pc_inc  = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_sum_a   = {1'b0, r_a} + {1'b0, w_imm};
  assign w_sum_b   = {1'b0, r_b} + {1'b0, w_imm};

  // Decode the current instruction into next-state values for every register.
  always_comb begin
    w_pc_nxt  = w_pc_inc;
    w_a_nxt   = r_a;
    w_b_nxt   = r_b;
    w_led_nxt = r_led;
    w_c_nxt   = 1'b0;
    case (w_opcode)
      4'b0000: begin
        w_a_nxt = w_sum_a[DATA_W-1:0];
        w_c_nxt = w_sum_a[DATA_W];
      end
      4'b0101: begin
        w_b_nxt = w_sum_b[DATA_W-1:0];
        w_c_nxt = w_sum_b[DATA_W];
      end
      4'b0001: w_a_nxt   = r_b;
      4'b0100: w_b_nxt   = r_a;
      4'b0011: w_a_nxt   = w_imm;
      4'b0111: w_b_nxt   = w_imm;
      4'b0010: w_a_nxt   = in_port;
      4'b0110: w_b_nxt   = in_port;
      4'b1001: w_led_nxt = r_b;
      4'b1011: w_led_nxt = w_imm;
      4'b1111: w_pc_nxt  = w_target;
      4'b1110: begin
        if (r_c == 1'b0) begin
          w_pc_nxt = w_target;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      default: w_pc_nxt = w_pc_inc;
    endcase
  end

  // Architectural state: reset wins over enable; a disabled clock holds everything.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_pc  <= {ADDR_W{1'b0}};
      r_a   <= {DATA_W{1'b0}};
      r_b   <= {DATA_W{1'b0}};
      r_led <= {DATA_W{1'b0}};
      r_c   <= 1'b0;
    end else if (en) begin
      r_pc  <= w_pc_nxt;
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_led <= w_led_nxt;
      r_c   <= w_c_nxt;
    end else begin
      r_pc  <= r_pc;
      r_a   <= r_a;
      r_b   <= r_b;
      r_led <= r_led;
      r_c   <= r_c;
    end
  end

  assign addr   = r_pc;
  assign led    = r_led;
  assign c_flag = r_c;

endmodule

// File: tb/tb_cpu_td_n.sv
// Directed test of cpu_td_n at 4/4 widths plus an 8/6 instance for width handling.
module tb_cpu_td_n;

  logic        clk;
  logic        n_rst;
  logic        en0;
  logic [3:0]  addr0;
  logic [7:0]  data0;
  logic [3:0]  in0;
  logic [3:0]  led0;
  logic        c0;

  logic        en1;
  logic [5:0]  addr1;
  logic [11:0] data1;
  logic [7:0]  in1;
  logic [7:0]  led1;
  logic        c1;

  int checks;
  int errors;

  cpu_td_n #(.DATA_W(4), .ADDR_W(4)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .en(en0), .addr(addr0), .data(data0),
    .in_port(in0), .led(led0), .c_flag(c0)
  );

  cpu_td_n #(.DATA_W(8), .ADDR_W(6)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .en(en1), .addr(addr1), .data(data1),
    .in_port(in1), .led(led1), .c_flag(c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exec0(input logic [7:0] instr);
    data0 = instr;
    step();
  endtask

  task automatic exec1(input logic [11:0] instr);
    data1 = instr;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_rst = 1'b0;
    en0   = 1'b1;
    en1   = 1'b0;
    in0   = 4'h0;
    in1   = 8'h00;
    data1 = 12'h000;

    // Reset with random instructions on the bus
    data0 = 8'($urandom_range(0, 255));
    step();
    data0 = 8'($urandom_range(0, 255));
    step();
    check_eq("rst_addr", 32'(addr0), 32'h0);
    check_eq("rst_led", 32'(led0), 32'h0);
    check_eq("rst_c", 32'(c0), 32'h0);
    check_eq("rst_addr1", 32'(addr1), 32'h0);
    check_eq("rst_led1", 32'(led1), 32'h0);

    n_rst = 1'b1;
    exec0(8'h80);
    check_eq("nop_addr1", 32'(addr0), 32'h1);
    exec0(8'h80);
    check_eq("nop_addr2", 32'(addr0), 32'h2);

    // Carry: MOV A,3; ADD A,15; MOV B,A; OUT B
    exec0(8'h33);
    check_eq("mov_c", 32'(c0), 32'h0);
    exec0(8'h0F);
    check_eq("add_c", 32'(c0), 32'h1);
    exec0(8'h40);
    check_eq("movba_c", 32'(c0), 32'h0);
    exec0(8'h90);
    check_eq("outb_led", 32'(led0), 32'h2);
    check_eq("carry_addr", 32'(addr0), 32'h6);

    // JNC not taken with C=1, then taken with C=0
    exec0(8'h0F);
    check_eq("add2_c", 32'(c0), 32'h1);
    exec0(8'hE9);
    check_eq("jnc_nt_addr", 32'(addr0), 32'h8);
    check_eq("jnc_nt_c", 32'(c0), 32'h0);
    exec0(8'hE9);
    check_eq("jnc_t_addr", 32'(addr0), 32'h9);

    // I/O path
    in0 = 4'h5;
    exec0(8'h20);
    in0 = 4'h0;
    exec0(8'h40);
    exec0(8'h90);
    check_eq("in_led", 32'(led0), 32'h5);
    exec0(8'hBA);
    check_eq("outimm_led", 32'(led0), 32'hA);
    check_eq("io_addr", 32'(addr0), 32'hD);

    // PC wrap
    exec0(8'hFF);
    check_eq("jmp_addr", 32'(addr0), 32'hF);
    exec0(8'h80);
    check_eq("wrap_addr", 32'(addr0), 32'h0);

    // A=5+15 -> 4, C=1, then freeze for three cycles
    exec0(8'h0F);
    en0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data0 = 8'hB3;
      in0   = 4'($urandom_range(0, 15));
      step();
    end
    check_eq("hold_addr", 32'(addr0), 32'h1);
    check_eq("hold_led", 32'(led0), 32'hA);
    check_eq("hold_c", 32'(c0), 32'h1);
    en0 = 1'b1;

    // ADD B: B=5+12 -> 1 with carry
    exec0(8'h5C);
    check_eq("addb_c", 32'(c0), 32'h1);
    exec0(8'h90);
    check_eq("addb_led", 32'(led0), 32'h1);
    check_eq("addb_outc", 32'(c0), 32'h0);

    // MOV A,B; MOV B,7; IN B (9); OUT B
    exec0(8'h10);
    exec0(8'h77);
    in0 = 4'h9;
    exec0(8'h60);
    in0 = 4'h0;
    exec0(8'h90);
    check_eq("inb_led", 32'(led0), 32'h9);
    check_eq("inb_addr", 32'(addr0), 32'h7);

    // A=1+15 -> 0 with carry; then reset aborts an OUT
    exec0(8'h0F);
    check_eq("pre_rst_c", 32'(c0), 32'h1);
    n_rst = 1'b0;
    exec0(8'hB3);
    check_eq("mid_rst_addr", 32'(addr0), 32'h0);
    check_eq("mid_rst_led", 32'(led0), 32'h0);
    check_eq("mid_rst_c", 32'(c0), 32'h0);
    n_rst = 1'b1;

    // A reset to 0: OUT via B shows it
    exec0(8'h40);
    exec0(8'h90);
    check_eq("post_rst_led", 32'(led0), 32'h0);

    // Wide instance: DATA_W=8, ADDR_W=6
    en0 = 1'b0;
    en1 = 1'b1;
    exec1(12'hB77);
    check_eq("w_out_led", 32'(led1), 32'h77);
    exec1(12'h301);
    exec1(12'h0FF);
    check_eq("w_add_c", 32'(c1), 32'h1);
    exec1(12'h400);
    check_eq("w_mov_c", 32'(c1), 32'h0);
    exec1(12'h900);
    check_eq("w_add_led", 32'(led1), 32'h00);
    check_eq("w_addr", 32'(addr1), 32'h5);
    exec1(12'hFC5);
    check_eq("w_jmp_addr", 32'(addr1), 32'h05);
    exec1(12'hF3A);
    check_eq("w_jmp2_addr", 32'(addr1), 32'h3A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
